// File: rtl/mod12_sequencer.sv
// Modulo-12 step sequencer: a prescaled position counter (0..11) with run/pause/idle control,
// a synchronous load path and registered step/wrap/err pulses.
module mod12_sequencer #(
   parameter int unsigned DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       dir,
   input  logic       load,
   input  logic [0:3] load_val,
   output logic [0:3] code,
   output logic       step,
   output logic       wrap,
   output logic       err,
   output logic       running
);

   typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

   localparam logic [7:0] PrescMax = 8'(DIV - 1);

   state_e     state_q, state_d;
   logic [7:0] presc_q, presc_d;
   logic [3:0] code_q, code_d;
   logic       step_q, step_d;
   logic       wrap_q, wrap_d;
   logic       err_q, err_d;
   logic       running_q, running_d;

   logic [3:0] load_v;
   logic       load_ok;
   logic       due;

   // Port vectors are [0:3] with index 0 as MSB, so a plain copy keeps the numeric value.
   assign load_v  = load_val;
   assign load_ok = load && (load_v <= 4'd11);

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      code_d  = code_q;
      due     = 1'b0;

      case (state_q)
         StIdle: begin
            if (!stop && start) begin
               state_d = StRun;
               presc_d = '0;
            end
         end
         StRun: begin
            // A stop on a due cycle freezes the prescaler at its terminal value.
            if (stop) begin
               state_d = StPause;
            end else if (presc_q == PrescMax) begin
               presc_d = '0;
               due     = 1'b1;
            end else begin
               presc_d = presc_q + 8'd1;
            end
         end
         StPause: begin
            if (stop) begin
               state_d = StIdle;
               presc_d = '0;
               code_d  = '0;
            end else if (start) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d = StIdle;
            presc_d = '0;
            code_d  = '0;
         end
      endcase

      step_d = due && !load_ok;
      wrap_d = step_d && (dir ? (code_q == 4'd11) : (code_q == 4'd0));
      if (step_d) begin
         if (dir) code_d = (code_q == 4'd11) ? 4'd0 : code_q + 4'd1;
         else     code_d = (code_q == 4'd0) ? 4'd11 : code_q - 4'd1;
      end
      if (load_ok) code_d = load_v;

      err_d     = load && !load_ok;
      running_d = (state_d == StRun);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         presc_q   <= '0;
         code_q    <= '0;
         step_q    <= 1'b0;
         wrap_q    <= 1'b0;
         err_q     <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         code_q    <= code_d;
         step_q    <= step_d;
         wrap_q    <= wrap_d;
         err_q     <= err_d;
         running_q <= running_d;
      end
   end

   assign code    = code_q;
   assign step    = step_q;
   assign wrap    = wrap_q;
   assign err     = err_q;
   assign running = running_q;

endmodule
